// File: rtl/mult_div.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per RUN cycle; signs are applied at commit.
module mult_div #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    // Handshake: start_i is sampled only in IDLE (busy_o low); busy_o stays high for
    // exactly 32 cycles, then done_o pulses for one cycle while HI/LO hold the result.
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q;
    logic [1:0]         op_q;
    logic [Width-1:0]   a_q, b_q, mag_b_q;
    logic [2*Width-1:0] p_q, p_step, result;
    logic [Width-1:0]   hi_q, lo_q;
    logic               done_q;

    logic [Width-1:0]   a_mag_in, b_mag_in;
    logic [Width:0]     add_sum, sh_rem;
    logic [Width+1:0]   diff;
    logic               a_neg, b_neg;
    logic [Width-1:0]   quot, rem;

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // op bit 0 clear means a signed operation: iterate on magnitudes
    always_comb begin
        a_mag_in = (!op_i[0] && a_i[Width-1]) ? -a_i : a_i;
        b_mag_in = (!op_i[0] && b_i[Width-1]) ? -b_i : b_i;
    end

    always_comb begin
        add_sum = {1'b0, p_q[2*Width-1:Width]} + {1'b0, (p_q[0] ? mag_b_q : {Width{1'b0}})};
        sh_rem  = {p_q[2*Width-1:Width], p_q[Width-1]};
        diff    = {1'b0, sh_rem} - {2'b00, mag_b_q};
        p_step  = {add_sum, p_q[Width-1:1]};
        if (op_q[1]) begin
            if (!diff[Width+1])
                p_step = {diff[Width-1:0], p_q[Width-2:0], 1'b1};
            else
                p_step = {sh_rem[Width-1:0], p_q[Width-2:0], 1'b0};
        end
    end

    // Final HI/LO value, formed from the last step so it can commit on the same edge
    always_comb begin
        a_neg  = !op_q[0] && a_q[Width-1];
        b_neg  = !op_q[0] && b_q[Width-1];
        quot   = p_step[Width-1:0];
        rem    = p_step[2*Width-1:Width];
        result = (a_neg ^ b_neg) ? -p_step : p_step;
        if (op_q[1]) begin
            if (b_q == '0)
                result = {a_q, {Width{1'b1}}};
            else
                result = {(a_neg ? -rem : rem), ((a_neg ^ b_neg) ? -quot : quot)};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cnt_q == 5'd31) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            op_q    <= OpMult;
            a_q     <= '0;
            b_q     <= '0;
            mag_b_q <= '0;
            p_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start_i) begin
                    op_q    <= op_i;
                    a_q     <= a_i;
                    b_q     <= b_i;
                    mag_b_q <= b_mag_in;
                    p_q     <= {{Width{1'b0}}, a_mag_in};
                    cnt_q   <= '0;
                end else begin
                    if (hi_we_i) hi_q <= a_i;
                    if (lo_we_i) lo_q <= a_i;
                end
            end else begin
                p_q   <= p_step;
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    {hi_q, lo_q} <= result;
                    done_q       <= 1'b1;
                end
            end
        end
    end

    // OpMultu is named for readability of the op encoding alongside OpMult
    logic unused_ok;
    assign unused_ok = ^OpMultu;

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter Width, default 32, operand and HI/LO register width; only 32 is required to be supported.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  request to begin the operation selected by op_i.
REQ-005 SHALL have port op_i  input  2  operation select: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
REQ-006 SHALL have ports a_i, b_i  input  Width  operands: multiplicand/multiplier or dividend/divisor.
REQ-007 SHALL have ports hi_we_i, lo_we_i  input  1  direct writes of a_i into HI or LO, for MTHI/MTLO.
REQ-008 SHALL have port busy_o  output  1  high while an operation is in progress.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse after results commit.
REQ-010 SHALL have ports hi_o, lo_o  output  Width  current HI and LO register contents.

Function
REQ-011 SHALL implement FSM states IDLE and RUN, plus a 5-bit iteration counter.
REQ-012 SHALL move IDLE->RUN on a rising edge with start_i=1, latching op_i, a_i and b_i and clearing the counter; start_i SHALL be ignored in RUN.
REQ-013 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle, incrementing the counter.
REQ-014 SHALL, on the RUN edge where counter==31, write the final HI/LO, enter IDLE, and assert done_o for exactly the following cycle.
REQ-015 SHALL drive busy_o = (state==RUN) combinationally; busy_o SHALL be high for exactly 32 cycles per operation, and a new start SHALL be accepted in the first cycle busy_o is low.
REQ-016 SHALL, for MULT/MULTU, produce the 64-bit product as {HI,LO}; MULT is two's-complement signed, MULTU is unsigned.
REQ-017 SHALL, for DIV/DIVU, place the quotient in LO and the remainder in HI.
REQ-018 SHALL, for DIV, truncate the quotient toward zero and give the remainder the sign of the dividend; signed operations SHALL iterate on magnitudes and apply signs at commit.
REQ-019 SHALL, on divide-by-zero (DIV or DIVU), commit LO=all ones and HI=the dividend, still taking 32 cycles.
REQ-020 SHALL, on DIV 0x80000000 / 0xFFFFFFFF, commit LO=0x80000000 and HI=0 without error.
REQ-021 SHALL, in IDLE with start_i=0, load a_i into HI on hi_we_i and into LO on lo_we_i; both writes in one cycle SHALL both apply.
REQ-022 SHALL ignore hi_we_i/lo_we_i during RUN, and also in IDLE when start_i=1 in the same cycle (start wins).
REQ-023 SHALL leave hi_o/lo_o unchanged from the start edge until the commit edge.

Reset
REQ-024 SHALL, while rst_i is high and regardless of clock, force state IDLE, counter 0, busy_o=0, done_o=0, hi_o=0 and lo_o=0.
REQ-025 SHALL abandon any in-progress operation on reset, with no partial HI/LO commit after reset releases.

Verification
REQ-026 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy_o high 32 cycles, then HI=0xFFFFFFFE, LO=0x00000001, done_o pulsed once.
REQ-027 SHALL cover: MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-028 SHALL cover: DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=7; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-029 SHALL cover: second start_i plus hi_we_i at RUN cycle 5 -> both ignored; only the first operation's result commits, after 32 cycles.
REQ-030 SHALL cover: rst_i asserted mid-cycle at RUN cycle 10 -> busy_o, hi_o and lo_o go to 0 immediately, with no done_o pulse afterwards.
REQ-031 SHALL cover: IDLE with hi_we_i=lo_we_i=1 and a_i=0x12345678 -> both HI and LO read 0x12345678 on the next cycle.
